// File: rtl/mrd_pkg.sv
// mrd_pkg: shared definitions for the mixed-radix DFT memory stages.
//   - main FSM state encodings (Idle..Source)
//   - bank count and the bank one-hot helper shared by sink and source
//   - read-out FSM state and read sideband types
package mrd_pkg;

  localparam logic [2:0] FSM_IDLE        = 3'd0;
  localparam logic [2:0] FSM_SINK        = 3'd1;
  localparam logic [2:0] FSM_WAIT_TO_RD  = 3'd2;
  localparam logic [2:0] FSM_RD          = 3'd3;
  localparam logic [2:0] FSM_WAIT_WR_END = 3'd4;
  localparam logic [2:0] FSM_SOURCE      = 3'd5;

  localparam int N_BANK = 7;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_t;

  // Sideband that travels alongside a RAM read until its data returns.
  typedef struct packed {
    logic       valid;
    logic [2:0] bank;
    logic       sop;
    logic       eop;
  } rd_req_t;

  // Bank enable, MSB = bank 0 (same order the sink stage uses for wren).
  function automatic logic [N_BANK-1:0] onehot7(input logic [2:0] idx);
    return 7'b1000000 >> idx;
  endfunction

endpackage

// File: rtl/mrd_rd_pipe.sv
// mrd_rd_pipe: DEPTH-stage shift register for the read sideband.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous clear of every stage (drops the incoming entry too)
//   in_req      sideband of the read registered this edge
//   out_req     tail stage, aligned with valid RAM read data
//   busy        any stage holds a valid entry
module mrd_rd_pipe
  import mrd_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  rd_req_t in_req,
  output rd_req_t out_req,
  output logic    busy
);

  rd_req_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_req;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_req = stage_q[DEPTH-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | stage_q[i].valid;
  end

endmodule

// File: rtl/mrd_fsm_source.sv
// mrd_fsm_source: read-out stage of the mixed-radix DFT memory.
// On entry into Source it walks bank 0..6, then bumps the bank address, one
// read per cycle, and emits the returned samples as a framed stream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fsm, len          main FSM state; frame length (sampled at Source entry)
//   rdaddr[0:6]       per-bank read address (all lanes equal)
//   rden              one-hot bank read enable, bit 6 = bank 0
//   rddata[0:6]       per-bank read data {re, im}, RD_LAT cycles after rden
//   dout_re/dout_im   output sample (held while dout_valid is low)
//   dout_valid/sop/eop  stream framing
//   source_done       one-cycle pulse the cycle after dout_eop
//   len_err           sticky: bad len seen at Source entry
// Stream handshake: valid-only, no ready; a sample is transferred in every
// cycle dout_valid is high and the consumer must take it.
module mrd_fsm_source
  import mrd_pkg::*;
#(
  parameter int wADDR  = 8,
  parameter int wDATA  = 16,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           fsm,
  input  logic [11:0]          len,
  output logic [wADDR-1:0]     rdaddr [0:6],
  output logic [6:0]           rden,
  input  logic [2*wDATA-1:0]   rddata [0:6],
  output logic [wDATA-1:0]     dout_re,
  output logic [wDATA-1:0]     dout_im,
  output logic                 dout_valid,
  output logic                 dout_sop,
  output logic                 dout_eop,
  output logic                 source_done,
  output logic                 len_err
);

  localparam logic [31:0] CAP = 32'(N_BANK * (2 ** wADDR));

  rd_state_t        state_q, state_d;
  logic [2:0]       prev_fsm;
  logic [11:0]      len_q, len_d, pt_q, pt_d;
  logic [2:0]       idx_q, idx_d;
  logic [wADDR-1:0] addr_q, addr_d;
  logic [6:0]       rden_d;
  logic             len_err_d;
  rd_req_t          req_d, tail;
  logic             pipe_busy, entry, abort, len_bad, tail_ok;
  logic [2*wDATA-1:0] sel_word;

  assign entry   = (fsm == FSM_SOURCE) && (prev_fsm != FSM_SOURCE);
  // Leaving Source with anything still in flight kills the frame.
  assign abort   = (fsm != FSM_SOURCE) && ((state_q == RD_ACTIVE) || pipe_busy);
  assign len_bad = (len == 12'd0) || ({20'd0, len} > CAP);

  // pt/idx/addr always describe the read currently presented on rden/rdaddr,
  // so the entry edge itself registers read 0.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pt_d      = pt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    rden_d    = '0;
    len_err_d = len_err;
    req_d     = '0;
    if (entry) begin
      if (len_bad) begin
        len_err_d = 1'b1;
        state_d   = RD_IDLE;
      end else begin
        state_d    = RD_ACTIVE;
        len_d      = len;
        pt_d       = '0;
        idx_d      = '0;
        addr_d     = '0;
        rden_d     = onehot7(3'd0);
        req_d.valid = 1'b1;
        req_d.bank  = 3'd0;
        req_d.sop   = 1'b1;
        req_d.eop   = (len == 12'd1);
      end
    end else if (state_q == RD_ACTIVE) begin
      if (abort || (pt_q == len_q - 12'd1)) begin
        state_d = RD_IDLE;
      end else begin
        pt_d = pt_q + 12'd1;
        if (idx_q == 3'(N_BANK - 1)) begin
          idx_d  = '0;
          addr_d = addr_q + wADDR'(1);
        end else begin
          idx_d = idx_q + 3'd1;
        end
        rden_d      = onehot7(idx_d);
        req_d.valid = 1'b1;
        req_d.bank  = idx_d;
        req_d.eop   = (pt_d == len_q - 12'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RD_IDLE;
      prev_fsm <= FSM_IDLE;
      len_q    <= '0;
      pt_q     <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      rden     <= '0;
      len_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_fsm <= fsm;
      len_q    <= len_d;
      pt_q     <= pt_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      rden     <= rden_d;
      len_err  <= len_err_d;
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANK; b++) rdaddr[b] = addr_q;
  end

  mrd_rd_pipe #(.DEPTH(RD_LAT + 1)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .in_req  (req_d),
    .out_req (tail),
    .busy    (pipe_busy)
  );

  always_comb begin
    sel_word = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (tail.bank == 3'(b)) sel_word = rddata[b];
    end
  end

  assign tail_ok = tail.valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_re     <= '0;
      dout_im     <= '0;
      dout_valid  <= 1'b0;
      dout_sop    <= 1'b0;
      dout_eop    <= 1'b0;
      source_done <= 1'b0;
    end else begin
      dout_valid  <= tail_ok;
      dout_sop    <= tail_ok && tail.sop;
      dout_eop    <= tail_ok && tail.eop;
      source_done <= dout_valid && dout_eop;
      if (tail_ok) begin
        dout_re <= sel_word[2*wDATA-1:wDATA];
        dout_im <= sel_word[wDATA-1:0];
      end
    end
  end

endmodule

// File: doc/mrd_fsm_source.md
# mrd_fsm_source

Read-out stage of the mixed-radix DFT memory. Once the main FSM enters Source, this block walks the seven RAM banks in the same round-robin point order the sink stage used for writing: bank 0..6, then the bank address increments. It handles the RAM read latency and emits a framed complex sample stream (valid/sop/eop) to the next processing stage. It signals completion back to the FSM.

## Interface
Parameters:
- wADDR, 8: bank address width; capacity 7·2^wADDR points.
- wDATA, 16: width of each real/imag component.
- RD_LAT, 2: RAM read latency in cycles, from registered rdaddr/rden to valid rddata; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  **one clock; reset is asynchronous and active-low**.
- fsm  in  3  main FSM state; Source = 3'd5.
- len  in  12  frame length in points; sampled at Source entry.
- rdaddr[0:6]  out  7×wADDR  per-bank read address; all seven lanes carry the same value.
- rden  out  7  one-hot bank read enable; bit 6 = bank 0 (MSB-first, matching the sink wren order).
- rddata[0:6]  in  7×2·wDATA  per-bank read data, {re, im}.
- dout_re, dout_im  out  wDATA each  output sample.
- dout_valid  out  1  sample qualifier.
- dout_sop  out  1  first point of the frame.
- dout_eop  out  1  last point of the frame.
- source_done  out  1  one-cycle pulse to the FSM after a frame completes.
- len_err  out  1  sticky flag: len was 0 or greater than 7·2^wADDR at Source entry.

## Operation
- Entry detect: fsm==5 while the registered previous fsm is not 5. The block captures len, clears the point counter pt, clears bank_idx and bank_addr, and sets active.
- While active, each cycle:
  - Issues one read: rden = onehot(bank_idx); rdaddr = bank_addr.
  - Advances state: pt += 1. bank_idx wraps 6→0, and bank_addr increments on that wrap.
- The last read is issued at pt == len−1. active then clears and no further reads are issued.
- Request pipeline, RD_LAT+1 deep, carries {valid, bank_idx, sop, eop} alongside the RAM access. At the tail, rddata[bank_idx] is selected into dout_re/dout_im and registered.
- sop is set for pt==0; eop is set for pt==len−1. For len==1 both are set on the same sample.
- source_done pulses the cycle after dout_eop.
- Abort: if fsm leaves 5 while active, or while the pipeline is non-empty:
  - active clears at the next edge.
  - The whole pipeline valid chain flushes.
  - dout_valid is low from the following cycle.
  - No eop and no source_done are produced.
- len_err: on a bad len, no reads are issued, len_err sets, and source_done is not pulsed. len_err clears only on reset.
- Re-entry into Source (5 → other → 5) starts a new frame. Back-to-back frames are not pipelined.
- No backpressure. The downstream stage must accept one sample per cycle.

## Timing
- Let T be the first cycle in which fsm==5.
  - Read k is presented (registered) in cycle T+1+k.
  - dout for point k is valid in cycle T+2+RD_LAT+k.
  - source_done is in cycle T+3+RD_LAT+len−1.
- Reset values: rdaddr=0, rden=0, dout_re=dout_im=0, dout_valid=dout_sop=dout_eop=0, source_done=0, len_err=0.
- Reset asserted mid-frame clears everything immediately (asynchronous). After deassertion, the block waits for a fresh entry edge. If fsm is already 5 at that point, this counts as entry only when the prev-fsm register, reset to 0, differs from 5.
- Widths: pt is 12 bits. bank_addr is wADDR bits and must not wrap for legal len.
- dout_re/dout_im hold their last value when dout_valid is low.

## Structure
- Shared package mrd_pkg:
  - FSM state localparams (Idle=0, Sink=1, Wait_to_rd=2, Rd=3, Wait_wr_end=4, Source=5).
  - N_BANK=7.
  - onehot7 function, MSB = bank 0, shared with the sink stage.
- One sub-module: mrd_rd_pipe. It is a parameterised RD_LAT+1-stage shift register for the {valid, bank_idx, sop, eop} sideband, with a synchronous flush input.

## Test plan
- len=21, RD_LAT=2, RAM model stores its own address:
  - rden sequence is 1000000, 0100000 … 0000001 three times.
  - rdaddr runs 0 ×7, 1 ×7, 2 ×7.
  - dout_valid for 21 cycles starting at T+4.
  - sop at point 0, eop at point 20.
  - done at T+25.
- len=10 (not a multiple of 7):
  - last read is bank 2, addr 1.
  - eop on point 9.
  - exactly 10 valids.
- len=1: single sample with sop=eop=1, and done one cycle later.
- Abort: fsm drops 5→0 at point 8 of len=21. No eop, no done, and dout_valid is low within 2 cycles. A subsequent re-entry produces a full 21-point frame starting from addr 0.
- len=0 and len=7·256+1:
  - no rden activity.
  - len_err=1 and stays set.
  - no source_done.
- rst_n pulsed low mid-frame: all outputs 0 asynchronously. With fsm held at 5 after release, a new frame starts from point 0.
